// File: rtl/ex_branch_stage_pkg.sv
// Shared types and encodings for the EX branch stage.
// Flag/funct3 codes, squash FSM states and the output bundle.
package ex_branch_stage_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] FLG_LT    = 3'b100;
    localparam logic [2:0] FLG_EQ    = 3'b010;
    localparam logic [2:0] FLG_GT    = 3'b001;
    localparam logic [2:0] FLG_AUIPC = 3'b111;

    typedef enum logic {
        ST_NORMAL,
        ST_SQUASH
    } br_state_e;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        misalign;
    } ex_out_t;

endpackage

// File: rtl/ex_branch_stage_if.sv
// Handshake and data bundle between ALU, EX branch stage and MEM.
// master drives inputs and out_ready; slave is the stage.
interface ex_branch_stage_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [2:0]  alu_flags;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  br_funct3;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        flush_i;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [31:0] out_store_data;
    logic [4:0]  out_rd;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_reg_write;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign;

    modport master (
        output in_valid, alu_result, alu_flags, pc, imm,
        output rs2_data, rd, is_branch, is_jal, is_jalr,
        output br_funct3, mem_read, mem_write, reg_write,
        output flush_i, out_ready,
        input  in_ready, out_valid, out_result,
        input  out_store_data, out_rd, out_mem_read,
        input  out_mem_write, out_reg_write,
        input  redirect_valid, redirect_pc, misalign
    );

    modport slave (
        input  in_valid, alu_result, alu_flags, pc, imm,
        input  rs2_data, rd, is_branch, is_jal, is_jalr,
        input  br_funct3, mem_read, mem_write, reg_write,
        input  flush_i, out_ready,
        output in_ready, out_valid, out_result,
        output out_store_data, out_rd, out_mem_read,
        output out_mem_write, out_reg_write,
        output redirect_valid, redirect_pc, misalign
    );

endinterface

// File: rtl/ex_branch_stage_br_cond.sv
// Combinational taken/target decode for branch, jal and jalr.
// Unrecognised flag patterns never resolve a branch as taken.
module br_cond
    import ex_branch_stage_pkg::*;
(
    input  logic [2:0]  alu_flags,
    input  logic [2:0]  br_funct3,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [30:0] jalr_base,
    output logic        taken,
    output logic [31:0] target
);

    logic lt, eq, gt, cond;

    assign lt = (alu_flags == FLG_LT);
    assign eq = (alu_flags == FLG_EQ);
    assign gt = (alu_flags == FLG_GT);

    always_comb begin
        cond = 1'b0;
        case (br_funct3)
            F3_BEQ:           cond = eq;
            F3_BNE:           cond = lt | gt;
            F3_BLT, F3_BLTU:  cond = lt;
            F3_BGE, F3_BGEU:  cond = gt | eq;
            default:          cond = 1'b0;
        endcase
    end

    always_comb begin
        taken  = 1'b0;
        target = pc + imm;
        unique case (1'b1)
            is_jalr: begin
                taken  = 1'b1;
                target = {jalr_base, 1'b0};
            end
            is_jal:    taken = 1'b1;
            is_branch: taken = cond;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_branch_stage.sv
// EX branch stage: output register, redirect pulse and squash FSM.
// Wrong-path inputs after a redirect are drained, not forwarded.
module ex_branch_stage
    import ex_branch_stage_pkg::*;
#(
    parameter int unsigned SQUASH_DEPTH = 2
) (
    input logic               clk,
    input logic               rst_n,
    ex_branch_stage_if.slave  bus
);

    localparam logic [2:0] SQ_LOAD = 3'(SQUASH_DEPTH);

    br_state_e   state;
    logic [2:0]  squash_cnt;
    logic        out_valid_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;
    ex_out_t     out_q;
    ex_out_t     nxt;

    logic        taken;
    logic [31:0] target;
    logic        squashing;
    logic        accept;
    logic        transfer;
    logic        is_jump;

    br_cond u_br_cond (
        .alu_flags (bus.alu_flags),
        .br_funct3 (bus.br_funct3),
        .is_branch (bus.is_branch),
        .is_jal    (bus.is_jal),
        .is_jalr   (bus.is_jalr),
        .pc        (bus.pc),
        .imm       (bus.imm),
        .jalr_base (bus.alu_result[31:1]),
        .taken     (taken),
        .target    (target)
    );

    assign squashing    = (state == ST_SQUASH);
    assign bus.in_ready = squashing || !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign transfer     = out_valid_q && bus.out_ready;
    assign is_jump      = bus.is_jal || bus.is_jalr;

    // Branches never write memory or registers, taken or not.
    always_comb begin
        nxt            = '0;
        nxt.result     = is_jump ? bus.pc + 32'd4 : bus.alu_result;
        nxt.store_data = bus.rs2_data;
        nxt.rd         = bus.rd;
        nxt.mem_read   = bus.mem_read  && !bus.is_branch;
        nxt.mem_write  = bus.mem_write && !bus.is_branch;
        nxt.reg_write  = bus.reg_write && !bus.is_branch;
        nxt.misalign   = taken && target[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_NORMAL;
            squash_cnt       <= 3'd0;
            out_valid_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            out_q            <= '0;
        end else begin
            redirect_valid_q <= 1'b0;
            if (bus.flush_i) begin
                out_valid_q <= 1'b0;
                squash_cnt  <= 3'd0;
                state       <= ST_NORMAL;
            end else if (accept && squashing) begin
                squash_cnt <= squash_cnt - 3'd1;
                if (squash_cnt == 3'd1)
                    state <= ST_NORMAL;
                if (transfer)
                    out_valid_q <= 1'b0;
            end else if (accept) begin
                out_q       <= nxt;
                out_valid_q <= 1'b1;
                if (taken) begin
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= target;
                    squash_cnt       <= SQ_LOAD;
                    if (SQ_LOAD != 3'd0)
                        state <= ST_SQUASH;
                end
            end else if (transfer) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_result     = out_q.result;
    assign bus.out_store_data = out_q.store_data;
    assign bus.out_rd         = out_q.rd;
    assign bus.out_mem_read   = out_q.mem_read;
    assign bus.out_mem_write  = out_q.mem_write;
    assign bus.out_reg_write  = out_q.reg_write;
    assign bus.misalign       = out_q.misalign;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_branch_stage.sv
// Bench for ex_branch_stage: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_ex_branch_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ex_branch_stage_if bus ();

    ex_branch_stage #(.SQUASH_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic bit ref_taken(input int cls, input logic [2:0] fl,
                                     input logic [2:0] f3);
        bit lt, eq, gt;
        lt = (fl == 3'b100);
        eq = (fl == 3'b010);
        gt = (fl == 3'b001);
        if (cls == 2 || cls == 3) return 1'b1;
        if (cls != 1) return 1'b0;
        case (f3)
            3'd0:       return eq;
            3'd1:       return lt || gt;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return gt || eq;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.alu_result = '0;
        bus.alu_flags  = '0;
        bus.pc         = '0;
        bus.imm        = '0;
        bus.rs2_data   = '0;
        bus.rd         = '0;
        bus.is_branch  = 1'b0;
        bus.is_jal     = 1'b0;
        bus.is_jalr    = 1'b0;
        bus.br_funct3  = '0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.flush_i    = 1'b0;
    endtask

    // cls: 0 alu op, 1 branch, 2 jal, 3 jalr
    task automatic put(input int cls, input logic [31:0] res,
                       input logic [31:0] pc_, input logic [31:0] imm_,
                       input logic [2:0] fl, input logic [2:0] f3);
        bus.in_valid   = 1'b1;
        bus.alu_result = res;
        bus.pc         = pc_;
        bus.imm        = imm_;
        bus.alu_flags  = fl;
        bus.br_funct3  = f3;
        bus.is_branch  = (cls == 1);
        bus.is_jal     = (cls == 2);
        bus.is_jalr    = (cls == 3);
        bus.rs2_data   = res ^ 32'hA5A5_A5A5;
        bus.rd         = res[4:0];
        bus.reg_write  = 1'b1;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.out_valid, bus.redirect_valid, bus.misalign, bus.out_mem_read,
             bus.out_mem_write, bus.out_reg_write} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {bus.out_valid, bus.redirect_valid, bus.misalign,
                      bus.out_mem_read, bus.out_mem_write, bus.out_reg_write});
        end
        n_cmp++;
        if ({bus.out_result, bus.out_store_data, bus.redirect_pc,
             bus.out_rd} !== 101'b0) begin
            n_bad++;
            $display("FAIL reset_data: got %h %h %h %h want zeros",
                     bus.out_result, bus.out_store_data, bus.redirect_pc,
                     bus.out_rd);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_beq_squash();
        do_reset();
        put(1, 32'h0, 32'h100, 32'h20, 3'b010, 3'b000);
        @(negedge clk);
        n_cmp++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h120) begin
            n_bad++;
            $display("FAIL beq_redirect: got %b %h want 1 00000120",
                     bus.redirect_valid, bus.redirect_pc);
        end
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_reg_write !== 1'b0) begin
            n_bad++;
            $display("FAIL beq_out: got v=%b rw=%b want v=1 rw=0",
                     bus.out_valid, bus.out_reg_write);
        end
        for (int i = 0; i < 2; i++) begin
            put(0, 32'h11 + i, 32'h124, 0, 3'b000, 3'b000);
            @(negedge clk);
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.redirect_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL beq_discard%0d: got v=%b rv=%b want 0 0",
                         i, bus.out_valid, bus.redirect_valid);
            end
        end
        put(0, 32'h33, 32'h120, 0, 3'b000, 3'b000);
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h33) begin
            n_bad++;
            $display("FAIL beq_resume: got v=%b res=%h want 1 00000033",
                     bus.out_valid, bus.out_result);
        end
        idle();
    endtask

    task automatic test_blt_not_taken();
        do_reset();
        put(1, 32'h5, 32'h200, 32'h10, 3'b001, 3'b100);
        @(negedge clk);
        n_cmp++;
        if ({bus.out_valid, bus.redirect_valid, bus.out_reg_write} !== 3'b100 ||
            bus.out_result !== 32'h5) begin
            n_bad++;
            $display("FAIL blt_nt: got v/rv/rw=%b res=%h want 100 00000005",
                     {bus.out_valid, bus.redirect_valid, bus.out_reg_write},
                     bus.out_result);
        end
        idle();
    endtask

    task automatic test_jalr();
        do_reset();
        put(3, 32'h2003, 32'h40, 32'h0, 3'b000, 3'b000);
        @(negedge clk);
        n_cmp++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h2002) begin
            n_bad++;
            $display("FAIL jalr_redirect: got %b %h want 1 00002002",
                     bus.redirect_valid, bus.redirect_pc);
        end
        n_cmp++;
        if (bus.out_result !== 32'h44 || bus.misalign !== 1'b1 ||
            bus.out_reg_write !== 1'b1) begin
            n_bad++;
            $display("FAIL jalr_out: got res=%h mis=%b rw=%b want 44 1 1",
                     bus.out_result, bus.misalign, bus.out_reg_write);
        end
        idle();
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready = 1'b0;
        put(0, 32'hABCD, 32'h80, 0, 3'b000, 3'b000);
        @(negedge clk);
        put(0, 32'h1234, 32'h84, 0, 3'b000, 3'b000);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
                bus.out_result !== 32'hABCD) begin
                n_bad++;
                $display("FAIL stall%0d: got rdy=%b v=%b res=%h want 0 1 abcd",
                         i, bus.in_ready, bus.out_valid, bus.out_result);
            end
            @(negedge clk);
        end
        idle();
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_release: got v=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        put(2, 32'h0, 32'h300, 32'h40, 3'b000, 3'b000);
        @(negedge clk);
        put(0, 32'h55, 32'h304, 0, 3'b000, 3'b000);
        @(negedge clk);
        put(0, 32'h66, 32'h308, 0, 3'b000, 3'b000);
        bus.flush_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.redirect_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush: got v=%b rv=%b want 0 0",
                     bus.out_valid, bus.redirect_valid);
        end
        bus.flush_i = 1'b0;
        put(0, 32'h77, 32'h340, 0, 3'b000, 3'b000);
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h77) begin
            n_bad++;
            $display("FAIL flush_resume: got v=%b res=%h want 1 00000077",
                     bus.out_valid, bus.out_result);
        end
        idle();
    endtask

    task automatic test_jal_wrap();
        do_reset();
        put(2, 32'h0, 32'hFFFF_FFFC, 32'h8, 3'b000, 3'b000);
        @(negedge clk);
        n_cmp++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h4 ||
            bus.out_result !== 32'h0 || bus.misalign !== 1'b0) begin
            n_bad++;
            $display("FAIL jal_wrap: got rv=%b pc=%h res=%h mis=%b want 1 4 0 0",
                     bus.redirect_valid, bus.redirect_pc, bus.out_result,
                     bus.misalign);
        end
        idle();
    endtask

    task automatic test_reset_mid_squash();
        do_reset();
        put(2, 32'h0, 32'h500, 32'h10, 3'b000, 3'b000);
        @(negedge clk);
        idle();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.redirect_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got v=%b rv=%b want 0 0",
                     bus.out_valid, bus.redirect_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        put(0, 32'h99, 32'h600, 0, 3'b000, 3'b000);
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h99) begin
            n_bad++;
            $display("FAIL reset_resume: got v=%b res=%h want 1 00000099",
                     bus.out_valid, bus.out_result);
        end
        idle();
    endtask

    task automatic test_random();
        bit          m_vld, m_rv, tk, acc, exp_rdy;
        int          m_sq, cls;
        logic [31:0] m_rpc, tgt;
        logic [72:0] m_out, got;
        do_reset();
        m_vld = 0; m_rv = 0; m_sq = 0; m_rpc = '0; m_out = '0;
        for (int i = 0; i < 600; i++) begin
            n_cmp++;
            if (bus.out_valid !== m_vld || bus.redirect_valid !== m_rv) begin
                n_bad++;
                $display("FAIL rnd_valid@%0d: got v=%b rv=%b want %b %b",
                         i, bus.out_valid, bus.redirect_valid, m_vld, m_rv);
            end
            if (m_rv) begin
                n_cmp++;
                if (bus.redirect_pc !== m_rpc) begin
                    n_bad++;
                    $display("FAIL rnd_rpc@%0d: got %h want %h",
                             i, bus.redirect_pc, m_rpc);
                end
            end
            if (m_vld) begin
                got = {bus.out_result, bus.out_store_data, bus.out_rd,
                       bus.out_mem_read, bus.out_mem_write,
                       bus.out_reg_write, bus.misalign};
                n_cmp++;
                if (got !== m_out) begin
                    n_bad++;
                    $display("FAIL rnd_out@%0d: got %h want %h", i, got, m_out);
                end
            end
            cls = int'($urandom_range(0, 3));
            put(cls, $urandom, $urandom, $urandom, 3'($urandom), 3'($urandom));
            bus.rd         = 5'($urandom);
            bus.rs2_data   = $urandom;
            bus.mem_read   = 1'($urandom);
            bus.mem_write  = 1'($urandom);
            bus.reg_write  = 1'($urandom);
            bus.in_valid   = ($urandom_range(0, 3) != 0);
            bus.out_ready  = ($urandom_range(0, 2) != 0);
            bus.flush_i    = ($urandom_range(0, 29) == 0);
            #1;
            exp_rdy = (m_sq > 0) || !m_vld || bus.out_ready;
            n_cmp++;
            if (bus.in_ready !== exp_rdy) begin
                n_bad++;
                $display("FAIL rnd_ready@%0d: got %b want %b",
                         i, bus.in_ready, exp_rdy);
            end
            tk  = ref_taken(cls, bus.alu_flags, bus.br_funct3);
            tgt = (cls == 3) ? (bus.alu_result & 32'hFFFF_FFFE)
                             : bus.pc + bus.imm;
            acc = bus.in_valid && exp_rdy;
            m_rv = 0;
            if (bus.flush_i) begin
                m_vld = 0;
                m_sq  = 0;
            end else begin
                if (m_vld && bus.out_ready) m_vld = 0;
                if (acc && m_sq > 0) begin
                    m_sq = m_sq - 1;
                end else if (acc) begin
                    m_vld = 1;
                    m_out = {(cls >= 2) ? bus.pc + 32'd4 : bus.alu_result,
                             bus.rs2_data, bus.rd,
                             bus.mem_read && cls != 1,
                             bus.mem_write && cls != 1,
                             bus.reg_write && cls != 1,
                             tk && tgt[1]};
                    if (tk) begin
                        m_rv  = 1;
                        m_rpc = tgt;
                        m_sq  = 2;
                    end
                end
            end
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        idle();
        bus.out_ready = 1'b1;
        test_reset();
        test_beq_squash();
        test_blt_not_taken();
        test_jalr();
        test_backpressure();
        test_flush();
        test_jal_wrap();
        test_reset_mid_squash();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
